lcd_cmd_responder: RTL and testbench

Responder end of the LCD feed command interface. Accepts one-shot clear / write-line-1 / write-line-2 command strobes, deasserts `o_lcd_command_ready` while busy, and serializes each command into the PMOD CLS escape-sequence byte stream. The byte stream is handed to the downstream SPI byte transmitter over a valid/ready handshake. It sits between the LCD text feed FSM and the SPI driver, in the 20 MHz domain, gated by the 2.5 MHz clock enable.

---
 rtl/lcd_cmd_responder_if.sv | 42 ++++
 rtl/lcd_cmd_responder.sv | 143 ++++++++++++++
 tb/tb_lcd_cmd_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_responder_if.sv
// Command strobes, line text and the outgoing byte handshake between the LCD
// text feed FSM, this responder and the SPI byte transmitter.
interface lcd_cmd_responder_if;
    logic         i_lcd_wr_clear_display;
    logic         i_lcd_wr_text_line1;
    logic         i_lcd_wr_text_line2;
    logic [127:0] i_dat_ascii_line1;
    logic [127:0] i_dat_ascii_line2;
    logic         o_lcd_command_ready;
    logic         o_cmd_done;
    // Byte handshake: a byte moves on a ce edge where o_tx_valid and
    // i_tx_ready are both high; o_tx_byte is held stable while valid waits.
    logic [7:0]   o_tx_byte;
    logic         o_tx_valid;
    logic         i_tx_ready;

    modport slave (
        input  i_lcd_wr_clear_display,
        input  i_lcd_wr_text_line1,
        input  i_lcd_wr_text_line2,
        input  i_dat_ascii_line1,
        input  i_dat_ascii_line2,
        input  i_tx_ready,
        output o_lcd_command_ready,
        output o_cmd_done,
        output o_tx_byte,
        output o_tx_valid
    );

    modport master (
        output i_lcd_wr_clear_display,
        output i_lcd_wr_text_line1,
        output i_lcd_wr_text_line2,
        output i_dat_ascii_line1,
        output i_dat_ascii_line2,
        output i_tx_ready,
        input  o_lcd_command_ready,
        input  o_cmd_done,
        input  o_tx_byte,
        input  o_tx_valid
    );
endinterface

// File: rtl/lcd_cmd_responder.sv
// Turns clear / line1 / line2 command strobes into PMOD CLS escape-sequence
// bytes for the SPI transmitter, advancing only on 2.5 MHz clock-enable edges.
module lcd_cmd_responder #(
    parameter bit parm_fast_simulation = 1'b0
) (
    input  logic                  i_clk_20mhz,
    input  logic                  i_rst_20mhz,
    input  logic                  i_ce_2_5mhz,
    lcd_cmd_responder_if.slave    bus,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'd0,
        CMD_LINE1 = 2'd1,
        CMD_LINE2 = 2'd2
    } cmd_e;

    state_e       state_q, state_d;
    cmd_e         cmd_q, cmd_d;
    logic [4:0]   idx_q, idx_d;
    logic [127:0] line_q, line_d;
    logic [7:0]   tx_byte_q, tx_byte_d;
    logic         tx_valid_q, tx_valid_d;
    logic         cmd_done_q, cmd_done_d;
    logic [4:0]   last_idx;
    logic         any_req;
    logic         unused_parm;

    assign unused_parm = parm_fast_simulation;

    // Byte at position idx of the escape sequence; positions 6..21 are text columns 0..15.
    function automatic logic [7:0] seq_byte(input cmd_e cmd, input logic [127:0] line,
                                            input logic [4:0] idx);
        logic [3:0] col;
        logic [7:0] b;
        col = 4'(idx - 5'd6);
        case (idx)
            5'd0:    b = 8'h1B;
            5'd1:    b = 8'h5B;
            5'd2:    b = (cmd == CMD_CLEAR) ? 8'h6A : ((cmd == CMD_LINE1) ? 8'h30 : 8'h31);
            5'd3:    b = 8'h3B;
            5'd4:    b = 8'h30;
            5'd5:    b = 8'h48;
            default: b = line[{4'd15 - col, 3'b000} +: 8];
        endcase
        return b;
    endfunction

    assign any_req  = bus.i_lcd_wr_clear_display | bus.i_lcd_wr_text_line1 |
                      bus.i_lcd_wr_text_line2;
    assign last_idx = (cmd_q == CMD_CLEAR) ? 5'd2 : 5'd21;

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        line_d     = line_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        cmd_done_d = cmd_done_q;
        if (i_ce_2_5mhz) begin
            case (state_q)
                ST_IDLE: begin
                    cmd_done_d = 1'b0;
                    tx_valid_d = 1'b0;
                    if (any_req) begin
                        if (bus.i_lcd_wr_clear_display) begin
                            cmd_d  = CMD_CLEAR;
                            line_d = bus.i_dat_ascii_line1;
                        end else if (bus.i_lcd_wr_text_line1) begin
                            cmd_d  = CMD_LINE1;
                            line_d = bus.i_dat_ascii_line1;
                        end else begin
                            cmd_d  = CMD_LINE2;
                            line_d = bus.i_dat_ascii_line2;
                        end
                        idx_d      = 5'd0;
                        state_d    = ST_SEND;
                        tx_valid_d = 1'b1;
                        tx_byte_d  = 8'h1B;
                    end
                end
                ST_SEND: begin
                    if (tx_valid_q && bus.i_tx_ready) begin
                        if (idx_q == last_idx) begin
                            // Index stays at the terminal value; it is reloaded on the next accept.
                            state_d    = ST_DONE;
                            tx_valid_d = 1'b0;
                            tx_byte_d  = 8'h00;
                            cmd_done_d = 1'b1;
                        end else begin
                            idx_d     = idx_q + 5'd1;
                            tx_byte_d = seq_byte(cmd_q, line_q, idx_q + 5'd1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d    = ST_IDLE;
                    cmd_done_d = 1'b0;
                end
                default: begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    cmd_done_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_CLEAR;
            idx_q      <= 5'd0;
            line_q     <= 128'd0;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            cmd_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            line_q     <= line_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            cmd_done_q <= cmd_done_d;
        end
    end

    assign bus.o_lcd_command_ready = (state_q == ST_IDLE);
    assign bus.o_tx_byte           = tx_byte_q;
    assign bus.o_tx_valid          = tx_valid_q;
    assign bus.o_cmd_done          = cmd_done_q;
    assign o_dbg_state             = state_q;

endmodule

// File: tb/tb_lcd_cmd_responder.sv
// Directed bench for lcd_cmd_responder: command table plus hand-written
// sequences for stalls, reset abort, priority and clock-enable gaps.
module tb_lcd_cmd_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b0;
    logic [1:0] dbg_state;

    lcd_cmd_responder_if bus();

    lcd_cmd_responder #(.parm_fast_simulation(1'b0)) dut (
        .i_clk_20mhz (clk),
        .i_rst_20mhz (rst),
        .i_ce_2_5mhz (ce),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #25 clk = ~clk;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string        name;
        logic         clr;
        logic         l1;
        logic         l2;
        logic [127:0] t1;
        logic [127:0] t2;
        logic [1:0]   exp_cmd;
        int           exp_low;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // One ce edge; records the byte if it transfers on that edge.
    task automatic tick();
        logic       pend;
        logic [7:0] pb;
        repeat (3) @(negedge clk);
        ce   = 1'b1;
        pend = bus.o_tx_valid && bus.i_tx_ready && !rst;
        pb   = bus.o_tx_byte;
        @(negedge clk);
        ce = 1'b0;
        if (pend) got_q.push_back(pb);
    endtask

    task automatic build_exp(input logic [1:0] cmd, input logic [127:0] text);
        exp_q.delete();
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h5B);
        if (cmd == 2'd0) begin
            exp_q.push_back(8'h6A);
        end else begin
            exp_q.push_back(cmd == 2'd1 ? 8'h30 : 8'h31);
            exp_q.push_back(8'h3B);
            exp_q.push_back(8'h30);
            exp_q.push_back(8'h48);
            for (int c = 0; c < 16; c++) exp_q.push_back(text[127 - 8*c -: 8]);
        end
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({name, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        got_q.delete();
    endtask

    task automatic drain(input string name, input int budget, output int low, output int done);
        low  = 1;
        done = 0;
        for (int i = 0; i < budget && !bus.o_lcd_command_ready; i++) begin
            tick();
            if (!bus.o_lcd_command_ready) low++;
            if (bus.o_cmd_done) done++;
        end
        check({name, "_finished"}, bus.o_lcd_command_ready, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int low, done;
        got_q.delete();
        bus.i_dat_ascii_line1      = v.t1;
        bus.i_dat_ascii_line2      = v.t2;
        bus.i_tx_ready             = 1'b1;
        bus.i_lcd_wr_clear_display = v.clr;
        bus.i_lcd_wr_text_line1    = v.l1;
        bus.i_lcd_wr_text_line2    = v.l2;
        tick();
        bus.i_lcd_wr_clear_display = 1'b0;
        bus.i_lcd_wr_text_line1    = 1'b0;
        bus.i_lcd_wr_text_line2    = 1'b0;
        check({v.name, "_acc_ready"}, bus.o_lcd_command_ready, 0);
        check({v.name, "_acc_valid"}, bus.o_tx_valid, 1);
        check({v.name, "_acc_byte"}, bus.o_tx_byte, 8'h1B);
        drain(v.name, 100, low, done);
        check({v.name, "_ready_low"}, low, v.exp_low);
        check({v.name, "_done_cnt"}, done, 1);
        build_exp(v.exp_cmd, v.exp_cmd == 2'd2 ? v.t2 : v.t1);
        compare_stream(v.name);
    endtask

    initial begin
        logic [127:0] accel, hello, two, gyro, zz;
        int           low, done, stall_bad, frozen_bad, snap_n;
        logic [7:0]   prev, snap_b;
        logic         snap_v, snap_r;

        accel = "ACCEL X:+0.123 G";
        hello = "HELLO WORLD 1234";
        two   = "LINE TWO TEXT OK";
        gyro  = "GYRO Y:-1.500 DP";
        zz    = "ZZZZZZZZZZZZZZZZ";

        vecs[0] = '{"clear",  1'b1, 1'b0, 1'b0, hello, two, 2'd0, 4};
        vecs[1] = '{"line1",  1'b0, 1'b1, 1'b0, accel, two, 2'd1, 23};
        vecs[2] = '{"line2",  1'b0, 1'b0, 1'b1, hello, two, 2'd2, 23};
        vecs[3] = '{"l1_l2",  1'b0, 1'b1, 1'b1, gyro, two, 2'd1, 23};

        bus.i_lcd_wr_clear_display = 1'b0;
        bus.i_lcd_wr_text_line1    = 1'b0;
        bus.i_lcd_wr_text_line2    = 1'b0;
        bus.i_dat_ascii_line1      = '0;
        bus.i_dat_ascii_line2      = '0;
        bus.i_tx_ready             = 1'b1;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", bus.o_lcd_command_ready, 1);
        check("rst_valid", bus.o_tx_valid, 0);
        check("rst_byte", bus.o_tx_byte, 8'h00);
        check("rst_done", bus.o_cmd_done, 0);
        check("rst_state", dbg_state, 2'd0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // All three requests: clear wins, held line requests accepted next.
        got_q.delete();
        bus.i_dat_ascii_line1      = accel;
        bus.i_dat_ascii_line2      = two;
        bus.i_lcd_wr_clear_display = 1'b1;
        bus.i_lcd_wr_text_line1    = 1'b1;
        bus.i_lcd_wr_text_line2    = 1'b1;
        tick();
        bus.i_lcd_wr_clear_display = 1'b0;
        drain("prio_clear", 100, low, done);
        check("prio_clear_low", low, 4);
        build_exp(2'd0, accel);
        compare_stream("prio_clear");
        tick();
        bus.i_lcd_wr_text_line1 = 1'b0;
        bus.i_lcd_wr_text_line2 = 1'b0;
        check("prio_l1_acc", bus.o_lcd_command_ready, 0);
        drain("prio_l1", 100, low, done);
        check("prio_l1_low", low, 23);
        build_exp(2'd1, accel);
        compare_stream("prio_l1");

        // line2 with ready toggling and text changed mid-send.
        got_q.delete();
        bus.i_dat_ascii_line2   = two;
        bus.i_lcd_wr_text_line2 = 1'b1;
        tick();
        bus.i_lcd_wr_text_line2 = 1'b0;
        stall_bad = 0;
        for (int i = 0; i < 100 && !bus.o_lcd_command_ready; i++) begin
            bus.i_tx_ready = (i % 2 == 0);
            if (i == 5) bus.i_dat_ascii_line2 = zz;
            prev   = bus.o_tx_byte;
            snap_n = got_q.size();
            tick();
            if (got_q.size() == snap_n && bus.o_tx_valid && bus.o_tx_byte != prev) stall_bad++;
        end
        bus.i_tx_ready = 1'b1;
        check("tog_finished", bus.o_lcd_command_ready, 1);
        check("tog_stall_hold", stall_bad, 0);
        build_exp(2'd2, two);
        compare_stream("tog");

        // Reset after byte 10 of a line1 command.
        got_q.delete();
        bus.i_dat_ascii_line1   = accel;
        bus.i_lcd_wr_text_line1 = 1'b1;
        tick();
        bus.i_lcd_wr_text_line1 = 1'b0;
        for (int i = 0; i < 40 && got_q.size() < 11; i++) tick();
        check("abort_pre_cnt", got_q.size(), 11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", bus.o_tx_valid, 0);
        check("abort_ready", bus.o_lcd_command_ready, 1);
        check("abort_byte", bus.o_tx_byte, 8'h00);
        check("abort_done", bus.o_cmd_done, 0);
        repeat (4) tick();
        check("abort_no_more", got_q.size(), 11);
        check("abort_idle_valid", bus.o_tx_valid, 0);
        run_vec(vecs[0]);

        // ce held low for 50 clocks mid-send.
        got_q.delete();
        bus.i_dat_ascii_line1   = gyro;
        bus.i_lcd_wr_text_line1 = 1'b1;
        tick();
        bus.i_lcd_wr_text_line1 = 1'b0;
        repeat (5) tick();
        snap_b     = bus.o_tx_byte;
        snap_v     = bus.o_tx_valid;
        snap_r     = bus.o_lcd_command_ready;
        snap_n     = got_q.size();
        frozen_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.o_tx_byte != snap_b || bus.o_tx_valid != snap_v ||
                bus.o_lcd_command_ready != snap_r) frozen_bad++;
        end
        check("celow_frozen", frozen_bad, 0);
        check("celow_cnt", got_q.size(), 5);
        build_exp(2'd1, gyro);
        tick();
        check("celow_resume_cnt", got_q.size(), 6);
        check("celow_resume_byte", bus.o_tx_byte, exp_q[6]);
        drain("celow", 100, low, done);
        compare_stream("celow");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
